// File: rtl/pcm_dac_pkg.sv
// Shared widths, sample type and constants for the PCM-to-PWM audio DAC.
// Build option PCM_SIGMA_DELTA_EN selects the sigma-delta modulator in pcm_pwm_modulator.
package pcm_dac_pkg;

  localparam int unsigned PCM_W    = 8;
  localparam int unsigned PWM_BITS = 8;

  typedef logic [PCM_W-1:0] pcm_t;

  localparam pcm_t                  PCM_MIDSCALE = 8'h80;
  localparam logic [PWM_BITS-1:0]   PWM_CNT_MAX  = '1;

endpackage

// File: rtl/pcm_pwm_modulator.sv
// 1-bit audio modulator: PWM compare by default, first-order sigma-delta
// when PCM_SIGMA_DELTA_EN is defined. Output is registered either way.
module pcm_pwm_modulator
  import pcm_dac_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  pcm_t                cur_sample,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm_out
);

`ifdef PCM_SIGMA_DELTA_EN
  // acc bit 8 is the carry of the last add and doubles as the output bit
  logic [PCM_W:0] acc_q, acc_d;
  logic           unused_pwm_cnt;

  assign unused_pwm_cnt = ^pwm_cnt;

  always_comb begin
    acc_d = {1'b0, acc_q[PCM_W-1:0]} + (PCM_W+1)'(cur_sample);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign pwm_out = acc_q[PCM_W];
`else
  logic pwm_out_q, pwm_out_d;

  always_comb begin
    pwm_out_d = (pwm_cnt < cur_sample);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out_q <= 1'b0;
    end else begin
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;
`endif

endmodule

// File: rtl/pcm_pwm_dac.sv
// Consumer end of the PCM channel: one-deep sample buffer, sample-period pacing,
// underrun counting, and the 1-bit modulator (sigma-delta under PCM_SIGMA_DELTA_EN).
module pcm_pwm_dac
  import pcm_dac_pkg::*;
#(
  parameter int unsigned SAMPLE_PWM_PERIODS = 4
)
(
  input  logic       clk,
  input  logic       reset,
  input  pcm_t       pcm_in,
  input  logic       pcm_in_vld,
  output logic       pcm_in_rdy,
  output logic       pwm_out,
  output logic       sample_strobe,
  output logic [7:0] underrun_cnt
);

  localparam int unsigned      PER_W    = (SAMPLE_PWM_PERIODS > 1) ? $clog2(SAMPLE_PWM_PERIODS) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PWM_PERIODS - 1);
  localparam int unsigned      UND_W    = 8;
  localparam logic [UND_W-1:0] UND_MAX  = '1;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PER_W-1:0]    period_cnt_q, period_cnt_d;
  pcm_t                cur_sample_q, cur_sample_d;
  pcm_t                next_sample_q, next_sample_d;
  logic                next_full_q, next_full_d;
  logic                strobe_q, strobe_d;
  logic [UND_W-1:0]    underrun_q, underrun_d;
  logic                boundary_c;
  logic                xfer_c;

  assign boundary_c = (pwm_cnt_q == PWM_CNT_MAX) && (period_cnt_q == PER_LAST);
  assign pcm_in_rdy = !next_full_q && !reset;
  assign xfer_c     = pcm_in_vld && pcm_in_rdy;

  // A transfer can coincide with a boundary only when the buffer was empty,
  // so the load below never collides with the buffer drain.
  always_comb begin
    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
    period_cnt_d  = period_cnt_q;
    cur_sample_d  = cur_sample_q;
    next_sample_d = next_sample_q;
    next_full_d   = next_full_q;
    underrun_d    = underrun_q;
    strobe_d      = boundary_c;

    if (pwm_cnt_q == PWM_CNT_MAX) begin
      period_cnt_d = (period_cnt_q == PER_LAST) ? '0 : period_cnt_q + PER_W'(1);
    end

    if (xfer_c) begin
      next_sample_d = pcm_in;
      next_full_d   = 1'b1;
    end

    if (boundary_c) begin
      if (next_full_q) begin
        cur_sample_d = next_sample_q;
        next_full_d  = 1'b0;
      end else if (underrun_q != UND_MAX) begin
        underrun_d = underrun_q + UND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q     <= '0;
      period_cnt_q  <= '0;
      cur_sample_q  <= PCM_MIDSCALE;
      next_sample_q <= '0;
      next_full_q   <= 1'b0;
      strobe_q      <= 1'b0;
      underrun_q    <= '0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      period_cnt_q  <= period_cnt_d;
      cur_sample_q  <= cur_sample_d;
      next_sample_q <= next_sample_d;
      next_full_q   <= next_full_d;
      strobe_q      <= strobe_d;
      underrun_q    <= underrun_d;
    end
  end

  pcm_pwm_modulator u_mod (
    .clk        (clk),
    .reset      (reset),
    .cur_sample (cur_sample_q),
    .pwm_cnt    (pwm_cnt_q),
    .pwm_out    (pwm_out)
  );

  assign sample_strobe = strobe_q;
  assign underrun_cnt  = underrun_q;

endmodule
